// File: rtl/mmio_initiator.sv
// Single-outstanding MMIO initiator: turns core requests into write/read strobes toward a responder.
// Optional wait-limit abort is compiled in with `define MMIO_TIMEOUT_EN.
module mmio_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wready,
    input  logic        wvalid,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        rready,
    input  logic        rvalid,
    output logic [31:0] raddr,
    input  logic        rresp,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WREQ  = 2'd1,
        RREQ  = 2'd2,
        RWAIT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_progress;
    logic        w_timeout;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_rdata_nxt;

    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_raddr;

    // Strobes decode straight from the state register, so reset drops them immediately.
    assign req_ready = (r_state == IDLE);
    assign wready    = (r_state == WREQ);
    assign rready    = (r_state == RREQ);
    assign w_accept  = req_valid && req_ready;

    // A handshake that lands on the final allowed cycle still counts as progress.
    assign w_progress = ((r_state == WREQ)  && wvalid) ||
                        ((r_state == RREQ)  && rvalid) ||
                        ((r_state == RWAIT) && rresp);

`ifdef MMIO_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_wait_cnt;
    logic        r_rsp_err;

    assign w_timeout = (r_state != IDLE) && (r_wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 16'd0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wait_cnt <= 16'd0;
            end else if (r_state != IDLE) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            r_rsp_err <= w_timeout && !w_progress;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
    assign rsp_err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = req_write ? WREQ : RREQ;
                end
            end
            WREQ: begin
                if (wvalid) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = 32'd0;
                end
            end
            RREQ: begin
                if (rvalid) begin
                    w_state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                if (rresp) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = rdata;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_timeout && !w_progress) begin
            w_state_nxt     = IDLE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = 32'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_waddr     <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_raddr     <= 32'd0;
        end else begin
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            if (w_accept && req_write) begin
                r_waddr <= {req_addr[31:2], 2'b00};
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            if (w_accept && !req_write) begin
                r_raddr <= {req_addr[31:2], 2'b00};
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign raddr     = r_raddr;

endmodule
